// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter.
// Accepts a WIDTH-bit word on a LOAD/READY handshake and shifts it out
// one bit per ENABLE strobe on SER_OUT. SER_OUT is always the head of the
// shift register. Zeros are filled in behind the data, so SER_OUT is
// naturally 0 once a frame has fully drained.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for a new word; LOAD captures DATA_IN
// ST_SHIFT | frame in flight; each ENABLE edge advances one bit
// ST_FIN   | single cycle after the last bit; DONE pulse
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLOCK,
  input  logic             CLEAR,
  input  logic             ENABLE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic             READY,
  output logic             SER_OUT,
  output logic             SER_VALID,
  output logic             FRAME,
  output logic             DONE
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_FIN   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [WIDTH-1:0] load_word;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // Orient the captured word so the shifter always moves toward the MSB.
  always_comb begin
    load_word = DATA_IN;
    if (!MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        load_word[i] = DATA_IN[WIDTH-1-i];
      end
    end
  end

  // Next-state, shifter and bit-counter update.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (LOAD) begin
          shreg_nxt = load_word;
          cnt_nxt   = '0;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ENABLE) begin
          shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
          cnt_nxt   = cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state_nxt = ST_FIN;
          end
        end
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
        shreg_nxt = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State and datapath registers; CLEAR aborts any frame in flight.
  always_ff @(posedge CLOCK) begin
    if (CLEAR) begin
      state <= ST_IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs come only from registers and state decode.
  assign READY     = (state == ST_IDLE);
  assign SER_VALID = (state == ST_SHIFT);
  assign SER_OUT   = shreg[WIDTH-1];
  assign FRAME     = (state == ST_SHIFT) && (cnt == '0);
  assign DONE      = (state == ST_FIN);

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: an MSB-first instance carries most of the
// sequence, and an LSB-first instance covers bit ordering.
module tb_piso_tx;

  logic       clk;
  logic       clear;
  logic       enable;
  logic       load;
  logic [7:0] data_in;
  logic       ready, ser_out, ser_valid, frame, done;

  logic       load_l;
  logic [7:0] data_l;
  logic       ready_l, ser_out_l, ser_valid_l, frame_l, done_l;

  int checks = 0;
  int errors = 0;

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
    .CLOCK(clk), .CLEAR(clear), .ENABLE(enable), .LOAD(load),
    .DATA_IN(data_in), .READY(ready), .SER_OUT(ser_out),
    .SER_VALID(ser_valid), .FRAME(frame), .DONE(done)
  );

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .CLOCK(clk), .CLEAR(clear), .ENABLE(enable), .LOAD(load_l),
    .DATA_IN(data_l), .READY(ready_l), .SER_OUT(ser_out_l),
    .SER_VALID(ser_valid_l), .FRAME(frame_l), .DONE(done_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] w;
    logic [7:0] w2;
    int dn;
    int gap;

    clear   = 1'b1;
    enable  = 1'b0;
    load    = 1'b0;
    data_in = 8'h00;
    load_l  = 1'b0;
    data_l  = 8'h00;

    // Reset with random LOAD/ENABLE
    for (int k = 0; k < 2; k++) begin
      load    = 1'($urandom_range(0, 1));
      enable  = 1'($urandom_range(0, 1));
      data_in = 8'($urandom);
      tick();
      check("rst_ready", ready, 1'b1);
      check("rst_ser_out", ser_out, 1'b0);
      check("rst_ser_valid", ser_valid, 1'b0);
      check("rst_frame", frame, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ready_lsb", ready_l, 1'b1);
    end
    clear  = 1'b0;
    load   = 1'b0;
    enable = 1'b0;
    tick();
    check("idle_ready", ready, 1'b1);

    // Basic frame A5, ENABLE constant
    w       = 8'hA5;
    enable  = 1'b1;
    load    = 1'b1;
    data_in = w;
    tick();
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("a5_bit", ser_out, w[7-i]);
      check("a5_frame", frame, (i == 0));
      check("a5_valid", ser_valid, 1'b1);
      check("a5_ready", ready, 1'b0);
      check("a5_done", done, 1'b0);
      tick();
    end
    check("a5_fin_done", done, 1'b1);
    check("a5_fin_ready", ready, 1'b0);
    check("a5_fin_valid", ser_valid, 1'b0);
    check("a5_fin_ser", ser_out, 1'b0);
    tick();
    check("a5_idle_ready", ready, 1'b1);
    check("a5_idle_done", done, 1'b0);

    // Gated rate, 3C, each bit held two cycles
    w       = 8'h3C;
    enable  = 1'b0;
    load    = 1'b1;
    data_in = w;
    tick();
    load = 1'b0;
    dn   = 0;
    for (int c = 0; c < 16; c++) begin
      check("gate_bit", ser_out, w[7-c/2]);
      check("gate_valid", ser_valid, 1'b1);
      if (done) dn++;
      enable = (c % 2 == 1);
      tick();
    end
    check("gate_fin_done", done, 1'b1);
    if (done) dn++;
    enable = 1'b1;
    tick();
    if (done) dn++;
    check_int("gate_done_count", dn, 1);
    check("gate_idle_ready", ready, 1'b1);

    // LSB first, 01
    enable = 1'b1;
    load_l = 1'b1;
    data_l = 8'h01;
    tick();
    load_l = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("lsb_bit", ser_out_l, (i == 0));
      check("lsb_valid", ser_valid_l, 1'b1);
      check("lsb_frame", frame_l, (i == 0));
      tick();
    end
    check("lsb_done", done_l, 1'b1);
    tick();
    check("lsb_ready", ready_l, 1'b1);

    // Busy: LOAD of FF during bits 2-5 of a 00 frame is ignored
    enable  = 1'b1;
    load    = 1'b1;
    data_in = 8'h00;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("busy_bit", ser_out, 1'b0);
      check("busy_valid", ser_valid, 1'b1);
      check("busy_frame", frame, (i == 0));
      load    = (i >= 1 && i <= 4);
      data_in = load ? 8'hFF : 8'h00;
      tick();
    end
    load    = 1'b0;
    data_in = 8'h00;
    check("busy_done", done, 1'b1);
    tick();
    check("busy_ready", ready, 1'b1);
    check("busy_idle_valid", ser_valid, 1'b0);
    tick();
    check("busy_no_ff_valid", ser_valid, 1'b0);
    check("busy_no_ff_ser", ser_out, 1'b0);

    // Abort with CLEAR at bit 4
    w       = 8'hA5;
    load    = 1'b1;
    data_in = w;
    tick();
    load = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("abort_bit4", ser_out, w[4]);
    check("abort_frame", frame, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("abort_ready", ready, 1'b1);
    check("abort_valid", ser_valid, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_ser", ser_out, 1'b0);
    tick();
    check("abort_done_after", done, 1'b0);
    check("abort_ready_after", ready, 1'b1);

    // Back-to-back 81 then 7E with LOAD held
    w       = 8'h81;
    w2      = 8'h7E;
    enable  = 1'b1;
    load    = 1'b1;
    data_in = w;
    tick();
    data_in = w2;
    dn  = 0;
    gap = 0;
    for (int c = 1; c <= 21; c++) begin
      logic ev;
      logic eb;
      ev = (c <= 8) || (c >= 11 && c <= 18);
      if (c <= 8) eb = w[8-c];
      else if (c >= 11 && c <= 18) eb = w2[18-c];
      else eb = 1'b0;
      check("b2b_valid", ser_valid, ev);
      check("b2b_bit", ser_out, eb);
      check("b2b_done", done, (c == 9 || c == 19));
      if (done) dn++;
      if (c > 8 && c < 11 && !ser_valid) gap++;
      if (c == 11) load = 1'b0;
      tick();
    end
    check_int("b2b_done_count", dn, 2);
    check_int("b2b_gap", gap, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
Parallel-in/serial-out transmitter. It accepts a WIDTH-bit word through a LOAD/READY handshake and shifts it out one bit at a time on SER_OUT. The bit rate is gated by an ENABLE strobe. It is the sending end for the DFF-chain serial capture path: SER_OUT drives the D_IN of a receiving register chain, and ENABLE is shared with that chain's ENABLE.

Parameters:
WIDTH, 8, word length in bits (>= 2)
MSB_FIRST, 1, 1 = transmit DATA_IN[WIDTH-1] first; 0 = DATA_IN[0] first

Ports:
CLOCK  input  1  single clock; all state updates on the rising edge
CLEAR  input  1  synchronous, active-high reset
ENABLE  input  1  bit-advance strobe; the shifter advances only on edges where ENABLE=1
LOAD  input  1  request to transmit DATA_IN
DATA_IN  input  WIDTH  word to transmit, sampled only when LOAD=1 and READY=1
READY  output  1  high when a new word can be accepted
SER_OUT  output  1  serial data, registered
SER_VALID  output  1  high while SER_OUT carries a frame bit
FRAME  output  1  high while the first bit of a frame is presented
DONE  output  1  one-cycle pulse after the last bit is consumed

Behaviour:
- CLEAR=1 at an edge:
  - state=IDLE, shift register=0, bit counter=0.
  - READY=1, SER_OUT=0, SER_VALID=0, FRAME=0, DONE=0.
  - CLEAR has priority over every other input, including mid-frame: the frame is aborted with no DONE pulse.
- State machine: IDLE, SHIFT, FIN.
- IDLE:
  - READY=1, SER_VALID=0, SER_OUT=0.
  - On an edge with LOAD=1: DATA_IN is captured (bit-reversed if MSB_FIRST=0, so the shift direction is fixed), counter=0, go to SHIFT.
  - ENABLE is ignored in IDLE.
- SHIFT:
  - READY=0, SER_VALID=1.
  - SER_OUT = head bit of the shift register.
  - FRAME=1 while counter==0.
  - On an edge with ENABLE=1: shift by one, counter += 1. If counter was WIDTH-1, go to FIN.
  - On an edge with ENABLE=0: hold everything. A bit may therefore be held for any number of cycles.
- FIN: exactly one cycle. DONE=1, READY=0, SER_VALID=0, SER_OUT=0. Next state is IDLE unconditionally.
- Handshake timing:
  - A transfer occurs on the edge where LOAD=1 and READY=1.
  - LOAD while READY=0 is ignored, not queued, and does not disturb the frame in flight.
  - Back-to-back frames: LOAD may be held high. The next word is taken on the first IDLE cycle, giving a 2-cycle gap (FIN, then IDLE) between the last bit and the next first bit.
- Latency: after a LOAD edge, SER_VALID=1 and the first bit is presented in the following cycle. With ENABLE constantly 1, a frame occupies WIDTH cycles, DONE appears in cycle WIDTH+1, and READY appears in cycle WIDTH+2.
- Counter width: clog2(WIDTH). No wrap is possible because the counter is cleared on every load.
- Simultaneous events:
  - LOAD and ENABLE both high in IDLE: the word is loaded, no shift occurs.
  - ENABLE high in FIN: no effect.
- Every output is a direct register or a decode of state only; there is no combinational path from any input to any output.

Test Plan:
- Reset: CLEAR=1 for 2 cycles with random LOAD/ENABLE -> READY=1, SER_OUT=0, SER_VALID=0, FRAME=0, DONE=0 on every cycle after the first edge.
- Basic frame: WIDTH=8, MSB_FIRST=1, ENABLE=1 constant, LOAD with DATA_IN=8'hA5 -> SER_OUT=1,0,1,0,0,1,0,1 on 8 consecutive cycles, FRAME high only on the first, DONE pulse in cycle 9, READY=1 in cycle 10.
- Gated rate: ENABLE toggling every cycle, DATA_IN=8'h3C -> each bit held exactly 2 cycles, sequence 0,0,1,1,1,1,0,0, DONE exactly once.
- LSB first: MSB_FIRST=0, DATA_IN=8'h01, ENABLE=1 -> SER_OUT=1 then seven 0s.
- Busy and abort:
  - LOAD=1 with DATA_IN=8'hFF during bits 2-5 of an 8'h00 frame -> the frame still outputs all zeros and the FF word is not sent.
  - A separate frame with CLEAR=1 asserted at bit 4 -> next cycle READY=1, SER_VALID=0, no DONE.
- Back-to-back: LOAD held high with 8'h81 then 8'h7E -> two complete frames, exactly 2 non-valid cycles between them, one DONE per frame.
